// File: rtl/alu_cmd_driver_pkg.sv
// Shared types for the alu_seq command driver.
// Covers opcodes, queued request records and driver FSM states.
package alu_cmd_driver_pkg;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        MULT,
        DIV
    } opcode_e;

    typedef struct packed {
        byte     op1;
        byte     op2;
        opcode_e opc;
    } alu_req_t;

    typedef enum logic [1:0] {
        DRV_IDLE,
        DRV_WAIT,
        DRV_HOLD
    } drv_state_e;

    function automatic logic is_div0(alu_req_t r);
        return (r.opc == DIV) && (r.op2 == 8'sd0);
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Request/response handshake bundle between host and alu_cmd_driver.
// The master side is the host; the slave side is the driver.
interface alu_cmd_driver_if;
    import alu_cmd_driver_pkg::*;

    logic    req_valid;
    logic    req_ready;
    byte     req_op1;
    byte     req_op2;
    opcode_e req_opcode;

    logic    rsp_valid;
    logic    rsp_ready;
    byte     rsp_data;
    opcode_e rsp_opcode;
    logic    rsp_div0;

    modport master (
        output req_valid, req_op1, req_op2, req_opcode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_opcode, rsp_div0
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_opcode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_opcode, rsp_div0
    );

endinterface

// File: rtl/alu_cmd_driver_fifo.sv
// Request queue for alu_cmd_driver: power-of-two depth, full/empty flags.
// Writes while full and reads while empty are ignored.
module alu_req_fifo
    import alu_cmd_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  alu_req_t din,
    input  logic     pop,
    output alu_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    alu_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands and issues them one at a time to alu_seq.
// DIV by zero is answered locally and never reaches the ALU.
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_driver_if.slave    bus,
    output byte                alu_operand1,
    output byte                alu_operand2,
    output opcode_e            alu_opcode,
    input  byte                alu_out,
    output logic               busy
);

    localparam int CNTW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    drv_state_e      state, nxt;
    alu_req_t        head;
    logic            full, empty, pop;
    logic [CNTW-1:0] cnt, cnt_d;
    byte             op1_d, op2_d, rd_d;
    opcode_e         opc_d, ro_d;
    logic            rv_d, r0_d;
    logic            rsp_valid_q, rsp_div0_q;
    byte             rsp_data_q;
    opcode_e         rsp_opcode_q;

    assign pop = (state == DRV_IDLE) && !empty;

    alu_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid),
        .din   ({bus.req_op1, bus.req_op2, bus.req_opcode}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.req_ready  = !full;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_opcode = rsp_opcode_q;
    assign bus.rsp_div0   = rsp_div0_q;
    assign busy           = !empty || (state != DRV_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= DRV_IDLE;
            cnt          <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_opcode   <= ADD;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_div0_q   <= 1'b0;
            rsp_opcode_q <= ADD;
        end else begin
            state        <= nxt;
            cnt          <= cnt_d;
            alu_operand1 <= op1_d;
            alu_operand2 <= op2_d;
            alu_opcode   <= opc_d;
            rsp_valid_q  <= rv_d;
            rsp_data_q   <= rd_d;
            rsp_div0_q   <= r0_d;
            rsp_opcode_q <= ro_d;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            DRV_IDLE: if (!empty) nxt = is_div0(head) ? DRV_HOLD : DRV_WAIT;
            DRV_WAIT: if (cnt == '0) nxt = DRV_HOLD;
            DRV_HOLD: if (bus.rsp_ready) nxt = DRV_IDLE;
            default:  nxt = DRV_IDLE;
        endcase
    end

    // Next values of the registered alu_* and rsp_* outputs
    always_comb begin
        cnt_d = cnt;
        op1_d = alu_operand1;
        op2_d = alu_operand2;
        opc_d = alu_opcode;
        rv_d  = rsp_valid_q;
        rd_d  = rsp_data_q;
        r0_d  = rsp_div0_q;
        ro_d  = rsp_opcode_q;
        unique case (state)
            DRV_IDLE: begin
                if (!empty) begin
                    ro_d = head.opc;
                    if (is_div0(head)) begin
                        rd_d = '0;
                        r0_d = 1'b1;
                        rv_d = 1'b1;
                    end else begin
                        op1_d = head.op1;
                        op2_d = head.op2;
                        opc_d = head.opc;
                        cnt_d = CNTW'(ALU_LAT);
                    end
                end
            end
            DRV_WAIT: begin
                if (cnt == '0) begin
                    rd_d = alu_out;
                    r0_d = 1'b0;
                    rv_d = 1'b1;
                end else begin
                    cnt_d = cnt - CNTW'(1);
                end
            end
            DRV_HOLD: begin
                if (bus.rsp_ready) begin
                    rv_d  = 1'b0;
                    op1_d = '0;
                    op2_d = '0;
                    opc_d = ADD;
                end
            end
            default: ;
        endcase
    end

endmodule
